encdec_mul_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one pipelined 16x16 unsigned multiplier among NUM_REQ

---
 rtl/encdec_mul_pkg.sv | 42 ++++
 rtl/encdec_mul_pipe.sv | 52 +++++
 rtl/encdec_mul_rr_sched.sv | 87 ++++++++
 tb/tb_encdec_mul_rr_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encdec_mul_pkg.sv
// Shared types and the round-robin search used by the multiplier scheduler.
package encdec_mul_pkg;

  localparam int DATA_W  = 16;
  localparam int PROD_W  = 2 * DATA_W;
  // Tag width is sized for the largest supported requester count so every
  // instance shares one tag type.
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t idx;
  } grant_t;

  // Rotate the request vector so that ptr sits at position 0, pick the
  // lowest set position, then map it back to the absolute index.
  // Walking the offsets downward lets the smallest offset win.
  function automatic grant_t rr_search(input logic [MAX_REQ-1:0] valid,
                                       input tag_t               ptr,
                                       input int                 n);
    grant_t            g;
    int                j;
    logic [TAG_W-1:0]  jt;
    g = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      jt = j[TAG_W-1:0];
      if (i < n) begin
        if (valid[jt]) begin
          g.found = 1'b1;
          g.idx   = jt;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/encdec_mul_pipe.sv
// Pipelined unsigned multiplier carrying a valid bit and requester tag.
// The product registers are plain enabled registers so synthesis can retime
// them into the DSP pipeline.
module encdec_mul_pipe
  import encdec_mul_pkg::tag_t;
#(
  parameter int DATA_W      = 16,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  tag_t                op_tag,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                res_valid,
  output tag_t                res_tag,
  output logic [2*DATA_W-1:0] res_p,
  output logic                busy
);

  logic [MUL_LATENCY-1:0] v;
  tag_t                   tag_q [MUL_LATENCY];
  logic [2*DATA_W-1:0]    p_q   [MUL_LATENCY];

  // Shift valid/tag every cycle; products only advance with a valid op so
  // the last stage holds the most recent delivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tag_q[k] <= '0;
        p_q[k]   <= '0;
      end
    end else begin
      v[0]     <= op_valid;
      tag_q[0] <= op_tag;
      if (op_valid) p_q[0] <= (2*DATA_W)'(op_a) * (2*DATA_W)'(op_b);
      for (int k = 1; k < MUL_LATENCY; k++) begin
        v[k]     <= v[k-1];
        tag_q[k] <= tag_q[k-1];
        if (v[k-1]) p_q[k] <= p_q[k-1];
      end
    end
  end

  assign res_valid = v[MUL_LATENCY-1];
  assign res_tag   = tag_q[MUL_LATENCY-1];
  assign res_p     = p_q[MUL_LATENCY-1];
  assign busy      = |v;

endmodule

// File: rtl/encdec_mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among requesters.
// Products return in issue order as a one-hot strobe to the issuing requester.
module encdec_mul_rr_sched
  import encdec_mul_pkg::tag_t;
  import encdec_mul_pkg::grant_t;
  import encdec_mul_pkg::MAX_REQ;
  import encdec_mul_pkg::rr_search;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int MUL_LATENCY = 3
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [2*DATA_W-1:0]       rsp_p,
  output logic                      busy,
  output logic [15:0]               issue_cnt
);

  logic [MAX_REQ-1:0] valid_ext;
  grant_t             grant;
  tag_t               rr_ptr;
  logic               hs;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic               res_valid;
  tag_t               res_tag;

  // Arbitrate from rr_ptr and steer the winner's operands to the multiplier.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
    grant                    = rr_search(valid_ext, rr_ptr, NUM_REQ);
    req_ready                = '0;
    a_sel                    = '0;
    b_sel                    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant.found && grant.idx == tag_t'(i)) begin
        req_ready[i] = !ap_rst;
        a_sel        = req_a[i*DATA_W +: DATA_W];
        b_sel        = req_b[i*DATA_W +: DATA_W];
      end
    end
    hs = |req_ready;
  end

  // Advance the pointer past the winner and count accepted operations.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr    <= '0;
      issue_cnt <= '0;
    end else if (hs) begin
      rr_ptr    <= (grant.idx == tag_t'(NUM_REQ - 1)) ? '0 : grant.idx + tag_t'(1);
      issue_cnt <= issue_cnt + 16'd1;
    end
  end

  encdec_mul_pipe #(
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_pipe (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .op_valid  (hs),
    .op_tag    (grant.idx),
    .op_a      (a_sel),
    .op_b      (b_sel),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .res_p     (rsp_p),
    .busy      (busy)
  );

  // Decode the output-stage tag into the one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = res_valid && (res_tag == tag_t'(i));
    end
  end

endmodule

// File: tb/tb_encdec_mul_rr_sched.sv
// Directed and random bench for the round-robin multiplier scheduler.
module tb_encdec_mul_rr_sched;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [2*DW-1:0] rsp_p;
  logic            busy;
  logic [15:0]     issue_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int m_ptr = 0;

  int          got_id[$];
  logic [31:0] got_p[$];
  int          got_cyc[$];
  int          exp_id[$];
  logic [31:0] exp_p[$];
  int          exp_cyc[$];

  encdec_mul_rr_sched #(.NUM_REQ(N), .DATA_W(DW), .MUL_LATENCY(LAT)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin r = i; c++; end
    if (c != 1) r = -1;
    return r;
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Log every response strobe with the cycle it was seen in.
  always @(negedge ap_clk) begin
    if (rsp_valid != '0) begin
      got_id.push_back(onehot_idx(rsp_valid));
      got_p.push_back(rsp_p);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic note_grant(input int g, input logic [15:0] a, input logic [15:0] b);
    exp_id.push_back(g);
    exp_p.push_back(32'(a) * 32'(b));
    exp_cyc.push_back(cyc + LAT);
    m_ptr = (g + 1) % N;
  endtask

  task automatic flush_q();
    got_id.delete(); got_p.delete(); got_cyc.delete();
    exp_id.delete(); exp_p.delete(); exp_cyc.delete();
  endtask

  task automatic test_reset();
    ap_rst    = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    tests++; if (rsp_p !== 32'h0) begin fails++; $display("FAIL reset_rsp_p got %h want 0", rsp_p); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (issue_cnt !== 16'h0) begin fails++; $display("FAIL reset_issue_cnt got %0d want 0", issue_cnt); end
    req_valid = '0;
    tick();
    ap_rst = 1'b0;
    m_ptr  = 0;
    flush_q();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    set_op(2, 16'h1234, 16'h0010);
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got %b want 0100", req_ready); end
    note_grant(2, 16'h1234, 16'h0010);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge ap_clk);
      tests++;
      if (rsp_valid !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
        fails++; $display("FAIL single_rsp_valid cycle+%0d got %b", k, rsp_valid);
      end
      tests++;
      if (busy !== (k <= 3)) begin fails++; $display("FAIL single_busy cycle+%0d got %b", k, busy); end
      if (k >= 3) begin
        tests++;
        if (rsp_p !== 32'h00012340) begin fails++; $display("FAIL single_rsp_p cycle+%0d got %h want 00012340", k, rsp_p); end
      end
    end
    tests++; if (issue_cnt !== 16'd1) begin fails++; $display("FAIL single_issue_cnt got %0d want 1", issue_cnt); end
    tick();
    flush_q();
  endtask

  task automatic test_rotation();
    int n[N];
    logic [15:0] a, b;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    m_ptr  = 0;
    flush_q();
    for (int i = 0; i < N; i++) n[i] = 0;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) set_op(i, 16'(16'h1000 * (i + 1) + n[i]), 16'(3 + n[i] + i));
      req_valid = 4'b1111;
      @(negedge ap_clk);
      tests++;
      if (req_ready !== 4'(1 << (t % N))) begin
        fails++; $display("FAIL rotation_grant step %0d got %b want %b", t, req_ready, 4'(1 << (t % N)));
      end
      a = req_a[(t % N)*DW +: DW];
      b = req_b[(t % N)*DW +: DW];
      note_grant(t % N, a, b);
      n[t % N]++;
      tick();
    end
    req_valid = '0;
    repeat (LAT + 1) tick();
    tests++; if (issue_cnt !== 16'd8) begin fails++; $display("FAIL rotation_issue_cnt got %0d want 8", issue_cnt); end
    tests++;
    if (got_id.size() != 8) begin fails++; $display("FAIL rotation_rsp_count got %0d want 8", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      tests++;
      if (got_id[i] != i % N || got_p[i] !== exp_p[i] || got_cyc[i] != exp_cyc[i]) begin
        fails++;
        $display("FAIL rotation_rsp %0d got id%0d p=%h c%0d want id%0d p=%h c%0d",
                 i, got_id[i], got_p[i], got_cyc[i], i % N, exp_p[i], exp_cyc[i]);
      end
    end
    flush_q();
  endtask

  task automatic test_arith();
    req_valid = 4'b0001;
    set_op(0, 16'hFFFF, 16'hFFFF);
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL arith_ready0 got %b want 0001", req_ready); end
    exp_id.push_back(0); exp_p.push_back(32'hFFFE0001); exp_cyc.push_back(cyc + LAT);
    m_ptr = 1;
    tick();
    set_op(0, 16'h0000, 16'hFFFF);
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL arith_ready1 got %b want 0001", req_ready); end
    exp_id.push_back(0); exp_p.push_back(32'h0); exp_cyc.push_back(cyc + LAT);
    m_ptr = 1;
    tick();
    req_valid = '0;
    repeat (LAT + 1) tick();
    tests++;
    if (got_id.size() != 2) begin fails++; $display("FAIL arith_rsp_count got %0d want 2", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      tests++;
      if (got_id[i] != exp_id[i] || got_p[i] !== exp_p[i] || got_cyc[i] != exp_cyc[i]) begin
        fails++;
        $display("FAIL arith_rsp %0d got id%0d p=%h c%0d want id%0d p=%h c%0d",
                 i, got_id[i], got_p[i], got_cyc[i], exp_id[i], exp_p[i], exp_cyc[i]);
      end
    end
    flush_q();
  endtask

  task automatic test_wrap();
    req_valid = 4'b0100;
    set_op(2, 16'h0002, 16'h0002);
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_setup got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1010;
    set_op(1, 16'h0011, 16'h0002);
    set_op(3, 16'h0033, 16'h0002);
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL wrap_first got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0010;
    @(negedge ap_clk);
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_second got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    m_ptr     = 2;
    repeat (LAT + 1) tick();
    tests++;
    if (got_id.size() != 3 || got_id[0] != 2 || got_id[1] != 3 || got_id[2] != 1 ||
        got_p[1] !== 32'h66 || got_p[2] !== 32'h22) begin
      fails++; $display("FAIL wrap_rsp_order got %0d responses, want ids 2,3,1", got_id.size());
    end
    flush_q();
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b0001;
    for (int t = 0; t < 3; t++) begin
      set_op(0, 16'(t + 5), 16'h0100);
      @(negedge ap_clk);
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_issue %0d got %b want 0001", t, req_ready); end
      tick();
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    ap_rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (issue_cnt !== 16'h0) begin fails++; $display("FAIL midrst_issue_cnt got %0d want 0", issue_cnt); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL midrst_ready got %b want 0000", req_ready); end
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    req_valid = '0;
    m_ptr     = 0;
    repeat (LAT + 4) tick();
    tests++; if (got_id.size() != 0) begin fails++; $display("FAIL midrst_rsp got %0d responses want 0", got_id.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy_after got %b want 0", busy); end
    flush_q();
  endtask

  task automatic test_random();
    bit pend[N];
    int wt[N];
    int max_wt = 0;
    int total  = 0;
    int g;
    for (int i = 0; i < N; i++) begin pend[i] = 0; wt[i] = 0; end
    for (int t = 0; t < 10000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[i] = 1;
            set_op(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
        req_valid[i] = pend[i];
      end
      @(negedge ap_clk);
      g = model_grant(req_valid, m_ptr);
      tests++;
      if (req_ready !== ((g < 0) ? 4'b0000 : 4'(1 << g))) begin
        fails++; $display("FAIL random_grant cycle %0d got %b model %0d", t, req_ready, g);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && i != g) begin
          wt[i]++;
          if (wt[i] > max_wt) max_wt = wt[i];
        end else begin
          wt[i] = 0;
        end
      end
      if (g >= 0) begin
        note_grant(g, req_a[g*DW +: DW], req_b[g*DW +: DW]);
        pend[g] = 0;
        total++;
      end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 2) tick();
    tests++; if (max_wt > N - 1) begin fails++; $display("FAIL random_starve max wait %0d limit %0d", max_wt, N - 1); end
    tests++; if (issue_cnt !== 16'(total)) begin fails++; $display("FAIL random_issue_cnt got %0d want %0d", issue_cnt, total); end
    tests++;
    if (got_id.size() != exp_id.size()) begin
      fails++; $display("FAIL random_rsp_count got %0d want %0d", got_id.size(), exp_id.size());
    end
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      tests++;
      if (got_id[i] != exp_id[i] || got_p[i] !== exp_p[i] || got_cyc[i] != exp_cyc[i]) begin
        fails++;
        $display("FAIL random_rsp %0d got id%0d p=%h c%0d want id%0d p=%h c%0d",
                 i, got_id[i], got_p[i], got_cyc[i], exp_id[i], exp_p[i], exp_cyc[i]);
      end
    end
    flush_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_arith();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
